// File: rtl/gesture_scorer_if.sv
//------------------------------------------------------------------------------
// gesture_scorer_if
//
// Bundles the inference request/response signals and the memory-side bus of
// the gesture scorer into one interface.
//
// Handshake: start is sampled only while busy=0. Once it is accepted, busy is
// high until the end of the cycle that carries done. start seen while busy is
// dropped, not queued. done is a one-cycle pulse. class_out and scores are
// valid from that cycle and hold until the next done or reset.
//
// Memory bus: cell_addr feeds the per-class weight ROMs and the feature memory.
// Both have a one-cycle synchronous read, so feat_in/w_in in cycle t+1 carry
// the data for the cell_addr of cycle t.
//
// Signals:
//   start         request one inference
//   cell_addr     cell address to weight ROMs / feature memory
//   feat_in       unsigned feature for the previous cycle's address
//   w_in          packed signed weights, class k at [k*WEIGHT_BITS +: WEIGHT_BITS]
//   busy          high in every FSM state except IDLE
//   done          one-cycle result pulse
//   class_out     winning class index
//   scores        packed signed final scores, class k at [k*ACC_BITS +: ACC_BITS]
//   gesture_valid qualifies class_out, pulses together with done
//   fsm_state     current FSM state, for debug
//
// Modports: slave = scorer side, master = requester / memory side.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface gesture_scorer_if #(
  parameter int NUM_CLASSES = 4,
  parameter int NUM_CELLS   = 1024,
  parameter int WEIGHT_BITS = 8,
  parameter int FEAT_BITS   = 8,
  parameter int ACC_BITS    = 24
);
  localparam int ADDR_W = $clog2(NUM_CELLS);
  localparam int CLS_W  = $clog2(NUM_CLASSES);

  logic                              start;
  logic [ADDR_W-1:0]                 cell_addr;
  logic [FEAT_BITS-1:0]              feat_in;
  logic [NUM_CLASSES*WEIGHT_BITS-1:0] w_in;
  logic                              busy;
  logic                              done;
  logic [CLS_W-1:0]                  class_out;
  logic [NUM_CLASSES*ACC_BITS-1:0]   scores;
  logic                              gesture_valid;
  logic [2:0]                        fsm_state;

  modport slave (
    input  start, feat_in, w_in,
    output cell_addr, busy, done, class_out, scores, gesture_valid, fsm_state
  );

  modport master (
    output start, feat_in, w_in,
    input  cell_addr, busy, done, class_out, scores, gesture_valid, fsm_state
  );
endinterface

// File: rtl/gesture_scorer.sv
//------------------------------------------------------------------------------
// gesture_scorer
//
// Scores NUM_CLASSES gesture classes in parallel over a grid of NUM_CELLS cells.
// Each class score is the saturating sum of feature x weight over all cells.
// The winner is then picked by a sequential argmax, one class per cycle.
//
// Parameters:
//   NUM_CLASSES  number of classes scored in parallel
//   NUM_CELLS    grid cells scanned per inference
//   WEIGHT_BITS  signed weight width
//   FEAT_BITS    unsigned feature width
//   ACC_BITS     signed score width; sums saturate at the bounds of this width
//   MIN_MARGIN   best-vs-runner-up threshold, only with the confidence option
//
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset; overrides everything
//   bus  gesture_scorer_if.slave (start, cell_addr, feat_in, w_in, busy, done,
//        class_out, scores, gesture_valid, fsm_state)
//
// Optional feature, macro GESTURE_SCORER_CONFIDENCE_EN:
//   When the macro is defined, the argmax also tracks the runner-up score.
//   gesture_valid is then raised only when best - runner-up >= MIN_MARGIN,
//   computed in ACC_BITS+1 bits.
//   When the macro is undefined, gesture_valid is identical to done.
//
// Timing: done rises NUM_CELLS + NUM_CLASSES + 2 cycles after the cycle in
// which start was sampled. This is NUM_CELLS SCAN cycles, one DRAIN cycle,
// NUM_CLASSES ARGMAX cycles, then DONE.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module gesture_scorer #(
  parameter int NUM_CLASSES = 4,
  parameter int NUM_CELLS   = 1024,
  parameter int WEIGHT_BITS = 8,
  parameter int FEAT_BITS   = 8,
  parameter int ACC_BITS    = 24,
  parameter int MIN_MARGIN  = 256
) (
  input logic            clk,
  input logic            rst,
  gesture_scorer_if.slave bus
);

  localparam int ADDR_W    = $clog2(NUM_CELLS);
  localparam int CLS_W     = $clog2(NUM_CLASSES);
  // The product of a zero-extended feature and a signed weight.
  localparam int PROD_BITS = FEAT_BITS + 1 + WEIGHT_BITS;
  // The sum width is one bit wider than either operand, so it can never wrap.
  localparam int SUM_BITS  = ((ACC_BITS > PROD_BITS) ? ACC_BITS : PROD_BITS) + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);
  localparam logic [CLS_W-1:0]  LAST_CLS  = CLS_W'(NUM_CLASSES - 1);

  localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    DRAIN  = 3'd2,
    ARGMAX = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                     state;
  logic [ADDR_W-1:0]          addr;
  logic [CLS_W-1:0]           arg_k;
  logic [CLS_W-1:0]           best_idx;
  logic signed [ACC_BITS-1:0] best;
  logic signed [ACC_BITS-1:0] acc [NUM_CLASSES];

  logic                            busy_r;
  logic                            done_r;
  logic                            gv_r;
  logic [CLS_W-1:0]                class_r;
  logic [NUM_CLASSES*ACC_BITS-1:0] scores_r;

  // Datapath signals.
  logic signed [FEAT_BITS:0]    feat_s;
  logic signed [PROD_BITS-1:0]  prod [NUM_CLASSES];
  logic                         acc_en;
  logic signed [ACC_BITS-1:0]   cur;
  logic signed [ACC_BITS-1:0]   nb;
  logic [CLS_W-1:0]             ni;

`ifdef GESTURE_SCORER_CONFIDENCE_EN
  localparam logic signed [ACC_BITS:0] MARGIN_T = (ACC_BITS+1)'(MIN_MARGIN);
  logic signed [ACC_BITS-1:0] second;
  logic signed [ACC_BITS-1:0] ns;
  logic signed [ACC_BITS:0]   margin;
  logic                       margin_ok;
`endif

  // Adds a product to an accumulator and clamps the result to the signed
  // ACC_BITS range. Clamping happens at every step. A saturated sum therefore
  // stays at its bound until a product of the opposite sign pulls it back.
  function automatic logic signed [ACC_BITS-1:0] sat_add(
    input logic signed [ACC_BITS-1:0]  a,
    input logic signed [PROD_BITS-1:0] p
  );
    logic signed [SUM_BITS-1:0] s;
    s = SUM_BITS'(a) + SUM_BITS'(p);
    if (s > SUM_BITS'(ACC_MAX)) begin
      sat_add = ACC_MAX;
    end else if (s < SUM_BITS'(ACC_MIN)) begin
      sat_add = ACC_MIN;
    end else begin
      sat_add = s[ACC_BITS-1:0];
    end
  endfunction

  assign feat_s = {1'b0, bus.feat_in};

  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      prod[k] = PROD_BITS'(feat_s) *
                PROD_BITS'($signed(bus.w_in[k*WEIGHT_BITS +: WEIGHT_BITS]));
    end
  end

  // Read data arrives one cycle after its address. Products are therefore
  // accumulated in every SCAN cycle except the first (addr 0 is issued there)
  // and in DRAIN. That gives exactly NUM_CELLS products per class. The scan
  // never wraps, so addr != 0 identifies "not the first SCAN cycle".
  assign acc_en = ((state == SCAN) && (addr != '0)) || (state == DRAIN);

  // One argmax step. Class 0 seeds the best score. A later class replaces it
  // only when strictly greater, so ties go to the lowest index.
  always_comb begin
    cur = acc[arg_k];
    nb  = best;
    ni  = best_idx;
`ifdef GESTURE_SCORER_CONFIDENCE_EN
    ns  = second;
`endif
    if (arg_k == '0) begin
      nb = cur;
      ni = '0;
`ifdef GESTURE_SCORER_CONFIDENCE_EN
      ns = ACC_MIN;
`endif
    end else if (cur > best) begin
      nb = cur;
      ni = arg_k;
`ifdef GESTURE_SCORER_CONFIDENCE_EN
      ns = best;
`endif
    end
`ifdef GESTURE_SCORER_CONFIDENCE_EN
    else if (cur > second) begin
      ns = cur;
    end
`endif
  end

`ifdef GESTURE_SCORER_CONFIDENCE_EN
  // The difference of two ACC_BITS values needs ACC_BITS+1 bits to be exact.
  always_comb begin
    margin    = {nb[ACC_BITS-1], nb} - {ns[ACC_BITS-1], ns};
    margin_ok = (margin >= MARGIN_T);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      arg_k    <= '0;
      best     <= '0;
      best_idx <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      gv_r     <= 1'b0;
      class_r  <= '0;
      scores_r <= '0;
`ifdef GESTURE_SCORER_CONFIDENCE_EN
      second   <= '0;
`endif
      for (int k = 0; k < NUM_CLASSES; k++) begin
        acc[k] <= '0;
      end
    end else begin
      done_r <= 1'b0;
      gv_r   <= 1'b0;

      if (acc_en) begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
          acc[k] <= sat_add(acc[k], prod[k]);
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= SCAN;
            busy_r <= 1'b1;
            addr   <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
              acc[k] <= '0;
            end
          end
        end

        SCAN: begin
          if (addr == LAST_ADDR) begin
            state <= DRAIN;
            addr  <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end

        DRAIN: begin
          state <= ARGMAX;
          arg_k <= '0;
        end

        ARGMAX: begin
          best     <= nb;
          best_idx <= ni;
`ifdef GESTURE_SCORER_CONFIDENCE_EN
          second   <= ns;
`endif
          if (arg_k == LAST_CLS) begin
            // The final step's comparison result goes straight to the outputs.
            state   <= DONE;
            arg_k   <= '0;
            done_r  <= 1'b1;
            class_r <= ni;
            for (int k = 0; k < NUM_CLASSES; k++) begin
              scores_r[k*ACC_BITS +: ACC_BITS] <= acc[k];
            end
`ifdef GESTURE_SCORER_CONFIDENCE_EN
            gv_r <= margin_ok;
`else
            gv_r <= 1'b1;
`endif
          end else begin
            arg_k <= arg_k + 1'b1;
          end
        end

        DONE: begin
          // start is deliberately not looked at here; a new request is only
          // accepted from IDLE on the following cycle.
          state  <= IDLE;
          busy_r <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          addr   <= '0;
        end
      endcase
    end
  end

  assign bus.cell_addr     = addr;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.gesture_valid = gv_r;
  assign bus.class_out     = class_r;
  assign bus.scores        = scores_r;
  assign bus.fsm_state     = state;

endmodule

// File: tb/tb_gesture_scorer.sv
//------------------------------------------------------------------------------
// tb_gesture_scorer
//
// Self-checking bench for gesture_scorer with default parameters.
// A synchronous-read memory model serves feat_in/w_in from feat_mem/w_mem.
// Expected results come either from a constant table or from a reference
// model that sums over the cell arrays with per-step clamping.
// Define GESTURE_SCORER_CONFIDENCE_EN for both the bench and the RTL to check
// the margin-qualified gesture_valid.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gesture_scorer;

  localparam int NC    = 4;
  localparam int NCELL = 1024;
  localparam int WB    = 8;
  localparam int FB    = 8;
  localparam int AB    = 24;
  localparam int MARG  = 256;
  localparam int LAT   = NCELL + NC + 2;

`ifdef GESTURE_SCORER_CONFIDENCE_EN
  localparam bit CONF = 1'b1;
`else
  localparam bit CONF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gesture_scorer_if #(
    .NUM_CLASSES(NC), .NUM_CELLS(NCELL), .WEIGHT_BITS(WB),
    .FEAT_BITS(FB), .ACC_BITS(AB)
  ) bus ();

  gesture_scorer #(
    .NUM_CLASSES(NC), .NUM_CELLS(NCELL), .WEIGHT_BITS(WB),
    .FEAT_BITS(FB), .ACC_BITS(AB), .MIN_MARGIN(MARG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- memories and scoreboard ----------------
  logic [FB-1:0]        feat_mem [NCELL];
  logic signed [WB-1:0] w_mem    [NCELL][NC];

  logic [AB-1:0] exp_q[$];
  int            exp_cls_q[$];
  bit            exp_gv_q[$];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int feat;
    int w     [NC];
    int exp_s [NC];
    int exp_cls;
    bit gv_conf;
  } vec_t;

  vec_t vecs [5];

  // Synchronous-read memory: data presented in a cycle belongs to the
  // address the DUT drove in the previous cycle.
  initial begin : rom_model
    int prev;
    prev = 0;
    bus.feat_in = '0;
    bus.w_in    = '0;
    forever begin
      @(negedge clk);
      bus.feat_in = feat_mem[prev];
      for (int k = 0; k < NC; k++) begin
        bus.w_in[k*WB +: WB] = w_mem[prev][k];
      end
      prev = int'(bus.cell_addr);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint score_of(input int k);
    logic [AB-1:0] v;
    v = bus.scores[k*AB +: AB];
    return longint'($signed(v));
  endfunction

  task automatic fill_uniform(input int feat, input int w [NC]);
    for (int c = 0; c < NCELL; c++) begin
      feat_mem[c] = FB'(feat);
      for (int k = 0; k < NC; k++) w_mem[c][k] = WB'(w[k]);
    end
  endtask

  task automatic fill_random();
    for (int c = 0; c < NCELL; c++) begin
      feat_mem[c] = 8'($urandom_range(0, 255));
      for (int k = 0; k < NC; k++) w_mem[c][k] = 8'($urandom_range(0, 255));
    end
  endtask

  // Reference model. It computes the clamped running sum per class, then
  // takes the first maximum and the best score among the remaining classes.
  task automatic model_push();
    longint s [NC];
    longint second;
    longint lim_hi;
    longint lim_lo;
    int     best;
    lim_hi = (longint'(1) <<< (AB - 1)) - 1;
    lim_lo = -(longint'(1) <<< (AB - 1));
    for (int k = 0; k < NC; k++) begin
      s[k] = 0;
      for (int c = 0; c < NCELL; c++) begin
        s[k] = s[k] + longint'(feat_mem[c]) * longint'(w_mem[c][k]);
        if (s[k] > lim_hi) s[k] = lim_hi;
        if (s[k] < lim_lo) s[k] = lim_lo;
      end
    end
    best = 0;
    for (int k = 1; k < NC; k++) if (s[k] > s[best]) best = k;
    second = -(longint'(1) <<< 40);
    for (int k = 0; k < NC; k++) if (k != best && s[k] > second) second = s[k];
    for (int k = 0; k < NC; k++) exp_q.push_back(AB'(s[k]));
    exp_cls_q.push_back(best);
    exp_gv_q.push_back(CONF ? ((s[best] - second) >= MARG) : 1'b1);
  endtask

  // ---------------- driver tasks ----------------
  // Counts cycles from the cycle in which start is sampled (cycle 0) until
  // done is seen. Also checks the address of every cycle on the way.
  task automatic wait_done(input bit pulse_mid, input bit hold);
    int cyc;
    int addr_err;
    cyc = 0;
    addr_err = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold) bus.start = 1'b0;
      if (pulse_mid && cyc == 501) bus.start = 1'b1;
      if (pulse_mid && cyc == 502) bus.start = 1'b0;
      if (cyc <= NCELL) begin
        if (int'(bus.cell_addr) != cyc - 1) addr_err++;
      end else if (bus.cell_addr != '0) begin
        addr_err++;
      end
      if (bus.done) break;
    end
    check("addr_seq_errors", addr_err, 0);
    check("done_latency", cyc, LAT);
  endtask

  task automatic compare_results();
    logic [AB-1:0] e [NC];
    int ec;
    bit eg;
    if (exp_q.size() < NC || exp_cls_q.size() == 0 || exp_gv_q.size() == 0) begin
      check("exp_queue_depth", exp_q.size(), NC);
      return;
    end
    for (int k = 0; k < NC; k++) begin
      e[k] = exp_q.pop_front();
      check($sformatf("score%0d", k), score_of(k), longint'($signed(e[k])));
    end
    ec = exp_cls_q.pop_front();
    eg = exp_gv_q.pop_front();
    check("class_out", longint'(bus.class_out), ec);
    check("gesture_valid", longint'(bus.gesture_valid), longint'(eg));
    check("done_high", longint'(bus.done), 1);
    check("busy_in_done", longint'(bus.busy), 1);
    @(negedge clk);
    check("done_pulse_width", longint'(bus.done), 0);
    check("gv_pulse_width", longint'(bus.gesture_valid), 0);
    check("busy_after_done", longint'(bus.busy), 0);
    check("class_hold", longint'(bus.class_out), ec);
    for (int k = 0; k < NC; k++) begin
      check($sformatf("score%0d_hold", k), score_of(k), longint'($signed(e[k])));
    end
  endtask

  task automatic run_inference(input bit pulse_mid);
    @(negedge clk);
    bus.start = 1'b1;
    wait_done(pulse_mid, 1'b0);
    compare_results();
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int zw [NC];
    int extra;

    vecs[0] = '{0,   '{5, -3, 7, 1},          '{0, 0, 0, 0},                          0, 1'b0};
    vecs[1] = '{10,  '{-4, -4, 6, -4},        '{-40960, -40960, 61440, -40960},       2, 1'b1};
    vecs[2] = '{255, '{127, 127, 127, 127},   '{8388607, 8388607, 8388607, 8388607},  0, 1'b0};
    vecs[3] = '{255, '{-128, -128, -128, -128}, '{-8388608, -8388608, -8388608, -8388608}, 0, 1'b0};
    vecs[4] = '{1,   '{3, 7, 7, -1},          '{3072, 7168, 7168, -1024},             1, 1'b0};

    zw = '{0, 0, 0, 0};
    fill_uniform(0, zw);
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy", longint'(bus.busy), 0);
    check("rst_done", longint'(bus.done), 0);
    check("rst_gesture_valid", longint'(bus.gesture_valid), 0);
    check("rst_class_out", longint'(bus.class_out), 0);
    check("rst_scores", longint'(bus.scores == '0), 1);
    check("rst_cell_addr", longint'(bus.cell_addr), 0);
    check("rst_fsm_idle", longint'(bus.fsm_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors with constant expectations.
    for (int i = 0; i < 5; i++) begin
      fill_uniform(vecs[i].feat, vecs[i].w);
      for (int k = 0; k < NC; k++) exp_q.push_back(AB'(vecs[i].exp_s[k]));
      exp_cls_q.push_back(vecs[i].exp_cls);
      exp_gv_q.push_back(CONF ? vecs[i].gv_conf : 1'b1);
      run_inference(1'b0);
    end

    // Random data against the reference model.
    for (int r = 0; r < 3; r++) begin
      fill_random();
      model_push();
      run_inference(1'b0);
    end

    // Saturate high (low for class 1), then pull back in the second half.
    for (int c = 0; c < NCELL; c++) begin
      feat_mem[c] = 8'd255;
      w_mem[c][0] = (c < NCELL / 2) ? 8'sd127 : -8'sd128;
      w_mem[c][1] = (c < NCELL / 2) ? -8'sd128 : 8'sd127;
      w_mem[c][2] = 8'sd0;
      w_mem[c][3] = 8'($urandom_range(0, 255));
    end
    model_push();
    run_inference(1'b0);

    // start pulsed mid-scan must be dropped: one done, no second run.
    fill_random();
    model_push();
    run_inference(1'b1);
    extra = 0;
    repeat (1100) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("extra_done_count", extra, 0);

    // start held high through DONE: ignored there, accepted in the next IDLE.
    fill_random();
    model_push();
    model_push();
    @(negedge clk);
    bus.start = 1'b1;
    wait_done(1'b0, 1'b1);
    compare_results();
    wait_done(1'b0, 1'b0);
    compare_results();

    // Reset in the middle of a scan.
    fill_random();
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 1; i <= 301; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", longint'(bus.busy), 0);
    check("midrst_scores", longint'(bus.scores == '0), 1);
    check("midrst_cell_addr", longint'(bus.cell_addr), 0);
    check("midrst_done", longint'(bus.done), 0);
    check("midrst_class_out", longint'(bus.class_out), 0);
    rst = 1'b0;
    fill_random();
    model_push();
    run_inference(1'b0);

    // Margin just below and exactly at the threshold.
    fill_uniform(0, zw);
    feat_mem[0] = 8'd255;
    w_mem[0][0] = 8'sd1;
    model_push();
    run_inference(1'b0);
    feat_mem[1] = 8'd1;
    w_mem[1][0] = 8'sd1;
    model_push();
    run_inference(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
